// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one registered 4-bit ALU between two
// requesters, with in-order tagged result return and divide-by-zero interception.
module alu_req_arbiter #(
  parameter int         ALU_LAT     = 1,
  parameter logic [7:0] DIV0_RESULT = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_fun,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_fun,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_fun,
  input  logic [7:0] alu_out,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_err
);

  logic               last_id;
  logic               grant0;
  logic               grant1;
  logic               grant_any;
  logic [3:0]         sel_a;
  logic [3:0]         sel_b;
  logic [1:0]         sel_fun;
  logic               sel_div0;
  logic [ALU_LAT-1:0] pipe_valid;
  logic [ALU_LAT-1:0] pipe_id;
  logic [ALU_LAT-1:0] pipe_div0;
  logic               tail_valid;

  // On contention the requester that did not win last time takes the slot.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!RST) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_id;
        grant1 = ~last_id;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign grant_any  = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    sel_a    = grant1 ? req1_a   : req0_a;
    sel_b    = grant1 ? req1_b   : req0_b;
    sel_fun  = grant1 ? req1_fun : req0_fun;
    sel_div0 = grant_any && (sel_fun == 2'b11) && (sel_b == 4'd0);
    alu_a    = 4'd0;
    alu_b    = 4'd0;
    alu_fun  = 2'b00;
    // A divide by zero is replaced by a harmless 0+0 so the ALU never sees it.
    if (grant_any && !sel_div0) begin
      alu_a   = sel_a;
      alu_b   = sel_b;
      alu_fun = sel_fun;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe_valid <= '0;
      pipe_id    <= '0;
      pipe_div0  <= '0;
      last_id    <= 1'b1;
    end else begin
      if (grant_any) begin
        last_id <= grant1;
      end
      pipe_valid[0] <= grant_any;
      pipe_id[0]    <= grant1;
      pipe_div0[0]  <= sel_div0;
      for (int i = 1; i < ALU_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
        pipe_div0[i]  <= pipe_div0[i-1];
      end
    end
  end

  // Responses are suppressed while reset is held so in-flight work is dropped at once.
  assign tail_valid = pipe_valid[ALU_LAT-1] && !RST;
  assign rsp_valid  = tail_valid;
  assign rsp_id     = tail_valid & pipe_id[ALU_LAT-1];
  assign rsp_err    = tail_valid & pipe_div0[ALU_LAT-1];
  assign rsp_data   = !tail_valid ? 8'h00 :
                      pipe_div0[ALU_LAT-1] ? DIV0_RESULT : alu_out;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: drives two arbiter builds (ALU_LAT=1 and ALU_LAT=3) with the
// same stimulus and compares both against a transaction-level reference model.
module tb_alu_req_arbiter;

  localparam logic [7:0] DIV0 = 8'h00;

  typedef struct {
    int         due;
    logic       id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_fun, req1_fun;

  logic [1:0] rdy0, rdy1;
  logic [3:0] alu_a [2];
  logic [3:0] alu_b [2];
  logic [1:0] alu_fun [2];
  logic [7:0] alu_out [2];
  logic [1:0] rsp_valid, rsp_id, rsp_err;
  logic [7:0] rsp_data [2];

  logic [7:0] alu_pipe1;
  logic [7:0] alu_pipe3 [3];

  int   n_compared = 0;
  int   n_mismatched = 0;
  int   cyc = 0;
  int   last_id = 1;
  logic model_g0 = 1'b0;
  logic model_g1 = 1'b0;
  logic seen_rdy0 = 1'b0;
  exp_t exp_q1[$];
  exp_t exp_q3[$];

  always #5 CLK = ~CLK;

  alu_req_arbiter #(.ALU_LAT(1), .DIV0_RESULT(DIV0)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_fun(alu_fun[0]), .alu_out(alu_out[0]),
    .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]), .rsp_data(rsp_data[0]), .rsp_err(rsp_err[0])
  );

  alu_req_arbiter #(.ALU_LAT(3), .DIV0_RESULT(DIV0)) dut3 (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_fun(alu_fun[1]), .alu_out(alu_out[1]),
    .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]), .rsp_data(rsp_data[1]), .rsp_err(rsp_err[1])
  );

  function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] f);
    case (f)
      2'b00:   return 8'(a) + 8'(b);
      2'b01:   return 8'(a) - 8'(b);
      2'b10:   return 8'(a) * 8'(b);
      default: return (b == 4'd0) ? 8'hFF : 8'(a / b);
    endcase
  endfunction

  // Registered ALUs of depth 1 and 3 feeding the two builds.
  always @(posedge CLK) begin
    alu_pipe1    <= alu_fn(alu_a[0], alu_b[0], alu_fun[0]);
    alu_pipe3[0] <= alu_fn(alu_a[1], alu_b[1], alu_fun[1]);
    alu_pipe3[1] <= alu_pipe3[0];
    alu_pipe3[2] <= alu_pipe3[1];
  end
  assign alu_out[0] = alu_pipe1;
  assign alu_out[1] = alu_pipe3[2];

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic v0, input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] f0,
                               input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] f1);
    logic       win_valid;
    logic       win_id;
    logic [3:0] wa, wb;
    logic [1:0] wf;
    logic       wdiv0;
    exp_t       e;
    logic       has_exp;
    RST = rst;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_fun = f0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_fun = f1;
    #1;
    win_valid = 1'b0;
    win_id    = 1'b0;
    if (!rst && v0 && v1) begin
      win_valid = 1'b1;
      win_id    = (last_id == 0) ? 1'b1 : 1'b0;
    end else if (!rst && (v0 || v1)) begin
      win_valid = 1'b1;
      win_id    = v1;
    end
    wa = win_id ? a1 : a0;
    wb = win_id ? b1 : b0;
    wf = win_id ? f1 : f0;
    wdiv0 = win_valid && (wf == 2'b11) && (wb == 4'd0);
    model_g0 = win_valid && !win_id;
    model_g1 = win_valid && win_id;
    seen_rdy0 = rdy0[0];
    if (rst) begin
      exp_q1.delete();
      exp_q3.delete();
    end
    for (int k = 0; k < 2; k++) begin
      has_exp = 1'b0;
      e = '{due: 0, id: 1'b0, data: 8'h00, err: 1'b0};
      if (k == 0 && exp_q1.size() > 0 && exp_q1[0].due == cyc) begin
        has_exp = 1'b1;
        e = exp_q1.pop_front();
      end
      if (k == 1 && exp_q3.size() > 0 && exp_q3[0].due == cyc) begin
        has_exp = 1'b1;
        e = exp_q3.pop_front();
      end
      checkOutput($sformatf("req0_ready[%0d]", k), 8'(rdy0[k]), 8'(model_g0));
      checkOutput($sformatf("req1_ready[%0d]", k), 8'(rdy1[k]), 8'(model_g1));
      checkOutput($sformatf("alu_a[%0d]", k), 8'(alu_a[k]), (win_valid && !wdiv0) ? 8'(wa) : 8'h00);
      checkOutput($sformatf("alu_b[%0d]", k), 8'(alu_b[k]), (win_valid && !wdiv0) ? 8'(wb) : 8'h00);
      checkOutput($sformatf("alu_fun[%0d]", k), 8'(alu_fun[k]), (win_valid && !wdiv0) ? 8'(wf) : 8'h00);
      checkOutput($sformatf("rsp_valid[%0d]", k), 8'(rsp_valid[k]), 8'(has_exp));
      checkOutput($sformatf("rsp_data[%0d]", k), rsp_data[k], e.data);
      checkOutput($sformatf("rsp_err[%0d]", k), 8'(rsp_err[k]), 8'(e.err));
      checkOutput($sformatf("rsp_id[%0d]", k), 8'(rsp_id[k]), 8'(e.id));
    end
    @(posedge CLK);
    if (rst) begin
      last_id = 1;
    end else if (win_valid) begin
      last_id = win_id ? 1 : 0;
      e.id   = win_id;
      e.err  = wdiv0;
      e.data = wdiv0 ? DIV0 : alu_fn(wa, wb, wf);
      e.due  = cyc + 1;
      exp_q1.push_back(e);
      e.due  = cyc + 3;
      exp_q3.push_back(e);
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
  endtask

  initial begin
    logic       rv0, rv1;
    logic [3:0] ra0, rb0, ra1, rb1;
    logic [1:0] rf0, rf1;
    logic       rrst;
    @(negedge CLK);

    // Reset and idle
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
    idle(10);

    // Single op 7+9
    applyStimulus(1'b0, 1'b1, 4'd7, 4'd9, 2'b00, 1'b0, 4'd0, 4'd0, 2'd0);
    checkOutput("single_data", rsp_data[0], 8'h10);
    checkOutput("single_valid", 8'(rsp_valid[0]), 8'h01);
    idle(3);

    // Contention from a fresh reset: 15*15 vs 3-5
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 4'd0, 4'd0, 2'd0);
    applyStimulus(1'b0, 1'b1, 4'd15, 4'd15, 2'b10, 1'b1, 4'd3, 4'd5, 2'b01);
    checkOutput("contend_first_grant", 8'(seen_rdy0), 8'h01);
    checkOutput("contend_data0", rsp_data[0], 8'hE1);
    applyStimulus(1'b0, 1'b1, 4'd15, 4'd15, 2'b10, 1'b1, 4'd3, 4'd5, 2'b01);
    checkOutput("contend_data1", rsp_data[0], 8'hFE);
    checkOutput("contend_id1", 8'(rsp_id[0]), 8'h01);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 4'd15, 4'd15, 2'b10, 1'b1, 4'd3, 4'd5, 2'b01);
    idle(3);

    // Divide by zero, then a legal divide
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 4'd9, 4'd0, 2'b11);
    checkOutput("div0_err", 8'(rsp_err[0]), 8'h01);
    checkOutput("div0_data", rsp_data[0], 8'h00);
    applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 4'd9, 4'd2, 2'b11);
    checkOutput("div_data", rsp_data[0], 8'h04);
    idle(3);

    // Reset mid-flight
    applyStimulus(1'b0, 1'b1, 4'd5, 4'd6, 2'b00, 1'b0, 4'd0, 4'd0, 2'd0);
    applyStimulus(1'b1, 1'b1, 4'd5, 4'd6, 2'b00, 1'b1, 4'd1, 4'd1, 2'b00);
    idle(4);
    applyStimulus(1'b0, 1'b1, 4'd2, 4'd2, 2'b00, 1'b1, 4'd1, 4'd1, 2'b00);
    checkOutput("post_reset_grant", 8'(seen_rdy0), 8'h01);
    idle(4);

    // Back-to-back ops observed through the ALU_LAT=3 build
    applyStimulus(1'b0, 1'b1, 4'd1, 4'd1, 2'b00, 1'b0, 4'd0, 4'd0, 2'd0);
    applyStimulus(1'b0, 1'b1, 4'd2, 4'd2, 2'b00, 1'b0, 4'd0, 4'd0, 2'd0);
    applyStimulus(1'b0, 1'b1, 4'd3, 4'd3, 2'b00, 1'b0, 4'd0, 4'd0, 2'd0);
    checkOutput("lat3_data0", rsp_data[1], 8'd2);
    idle(1);
    checkOutput("lat3_data1", rsp_data[1], 8'd4);
    idle(1);
    checkOutput("lat3_data2", rsp_data[1], 8'd6);
    idle(3);

    // Randomized traffic; a waiting requester holds its operation
    rv0 = 1'b0; rv1 = 1'b0;
    ra0 = 4'd0; rb0 = 4'd0; rf0 = 2'd0;
    ra1 = 4'd0; rb1 = 4'd0; rf1 = 2'd0;
    for (int n = 0; n < 500; n++) begin
      if (!(rv0 && !model_g0)) begin
        rv0 = ($urandom_range(0, 3) != 0);
        ra0 = 4'($urandom);
        rb0 = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
        rf0 = 2'($urandom);
      end
      if (!(rv1 && !model_g1)) begin
        rv1 = ($urandom_range(0, 3) != 0);
        ra1 = 4'($urandom);
        rb1 = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
        rf1 = 2'($urandom);
      end
      rrst = ($urandom_range(0, 60) == 0);
      applyStimulus(rrst, rv0, ra0, rb0, rf0, rv1, ra1, rb1, rf1);
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Round-robin scheduler that shares the single registered 4-bit ALU datapath between two requesters. Each requester issues operations over a valid/ready handshake. The arbiter grants at most one operation per cycle and steers that requester's operands and function code onto the ALU inputs. It tracks each in-flight operation through the ALU's latency and returns the 8-bit result to the owning requester, tagged with the requester ID. Divide-by-zero operations are intercepted so that the ALU never sees B=0 with a divide function.

## Interface
- ALU_LAT, 1, ALU result latency in cycles (≥1); must match the ALU's register depth.
- DIV0_RESULT, 8'h00, value returned in rsp_data for a divide-by-zero operation.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted this cycle (grant).
- req0_a, req0_b / req1_a, req1_b  in  4  operands.
- req0_fun / req1_fun  in  2  function code: 00 add, 01 sub, 10 mul, 11 div.
- alu_a, alu_b  out  4  ALU operand inputs.
- alu_fun  out  2  ALU function select.
- alu_out  in  8  ALU registered result.
- rsp_valid  out  1  result valid, one-cycle pulse per operation, no backpressure.
- rsp_id  out  1  requester that owns rsp_data.
- rsp_data  out  8  result.
- rsp_err  out  1  operation was a divide by zero; rsp_data = DIV0_RESULT.

## Operation
- Arbitration is combinational within the cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that was not granted last is granted.
  - Priority pointer last_id updates on every grant; it resets to 1, so req0 wins the first contested cycle.
- Grant: exactly one reqN_ready=1 in the cycle the operation is accepted. Ready is never asserted without the matching valid. Operands are sampled in that cycle only.
- Issue, normal operation: alu_a/alu_b/alu_fun are driven from the granted requester in the grant cycle.
- Issue, divide by zero (fun=11, b=0): alu_a/alu_b/alu_fun are driven 0/0/00, so the ALU computes a harmless add.
- No grant: alu_a/alu_b/alu_fun = 0.
- Tracking pipeline: ALU_LAT-deep shift register of {valid, id, div0}, loaded on each grant and otherwise loaded with valid=0.
- Response comes from the pipeline tail:
  - rsp_valid = tail.valid, rsp_id = tail.id, rsp_err = tail.div0.
  - rsp_data = DIV0_RESULT if div0, else alu_out.
  - rsp_data = 0 when rsp_valid=0.
- Result width: rsp_data passes alu_out through unmodified; no sign handling or saturation in the arbiter.
  - Sub underflow wraps as the ALU produces it, e.g. 3-5 → 8'hFE.
- Responses return in issue order. Throughput is one operation per cycle, with no bubbles between back-to-back grants.

## Timing
- Reset (RST=1 at an edge):
  - Pipeline valid bits clear and last_id=1.
  - During RST=1: req0_ready=req1_ready=0 and alu_* = 0.
  - Outputs after reset: rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
- Latency: operation granted in cycle t → rsp_valid=1 in cycle t+ALU_LAT. This holds for div0 operations too, preserving order.
- Reset mid-operation: in-flight operations are discarded. No rsp_valid appears after RST deasserts until new grants have aged ALU_LAT cycles.
- A requester holding valid while not granted must keep its operands stable. It is guaranteed a grant within 2 cycles.
- Both requesters continuously valid: grants alternate 0,1,0,1…

## Test plan
- Single op: req0 valid, a=7, b=9, fun=00 at cycle t → req0_ready at t; at t+1 rsp_valid=1, rsp_id=0, rsp_data=8'h10, rsp_err=0.
- Contention: both valid from cycle t, with req0 mul 15×15 and req1 sub 3−5 → grants 0,1,0,1. Responses alternate 8'hE1 (id0) and 8'hFE (id1), one per cycle.
- Divide by zero: req1 a=9, b=0, fun=11 → alu_a/alu_b/alu_fun all 0 in the grant cycle; at t+1 rsp_valid=1, rsp_id=1, rsp_err=1, rsp_data=8'h00. A following 9/2 returns 8'h04 with rsp_err=0.
- Reset mid-flight: grant at t, RST=1 at t+1 → no rsp_valid at t+1 or later; after reset the first contested cycle grants req0.
- ALU_LAT=3 build: back-to-back ops 1+1, 2+2, 3+3 → responses 2, 4, 6 at t+3, t+4, t+5 with correct IDs.
- Idle: both valid low for 10 cycles → ready low, alu_* = 0, rsp_valid stays 0.
